// File: rtl/uart_receive_pkg.sv
// Shared definitions for the UART receive path:
// receive FSM states plus oversampling and FIFO sizing constants.
package uart_receive_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int DEPTH      = 8;
   localparam int AW         = $clog2(DEPTH);
   localparam int CW         = AW + 1;

   // Sample-counter values: mid start bit and last tick of a bit.
   localparam logic [3:0] SMID  = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0] SLAST = 4'(OVERSAMPLE - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_e;

endpackage

// File: rtl/uart_receive_rx_fifo.sv
// Synchronous show-ahead receive FIFO of DEPTH bytes.
// Ports: clk_i, rst_ni, push_i/wdata_i, pop_i, rdata_o (head, 0 when empty),
//        count_o, full_o, empty_o.
module rx_fifo
   import uart_receive_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic [7:0]    wdata_i,
   input  logic          pop_i,
   output logic [7:0]    rdata_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = empty_o ? 8'h00 : mem_q[rptr_q];

   // A pop frees the slot, so a full FIFO still accepts a same-cycle push.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wptr_d = wptr_q + AW'(do_push);
      rptr_d = rptr_q + AW'(do_pop);
      cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_receive.sv
// UART receive path: RX synchroniser, baud divider, 8N1 receive FSM, RX FIFO.
// Ports: CLK, NRST, EN, BAUDDIV, RX, RD, CLRERR in;
//        RDATA, RXNE, RXFULL, COUNT, FERR, OVR out.
module uart_receive
   import uart_receive_pkg::*;
(
   input  logic       CLK,
   input  logic       NRST,
   input  logic       EN,
   input  logic [7:0] BAUDDIV,
   input  logic       RX,
   input  logic       RD,
   input  logic       CLRERR,
   output logic [7:0] RDATA,
   output logic       RXNE,
   output logic       RXFULL,
   output logic [3:0] COUNT,
   output logic       FERR,
   output logic       OVR
);

   logic       rx_m_q, rx_s_q;
   logic [7:0] div_q, div_d;
   logic       tick;
   rx_state_e  state_q, state_d;
   logic [3:0] scnt_q, scnt_d;
   logic [2:0] bidx_q, bidx_d;
   logic [7:0] sh_q, sh_d;
   logic       push, ferr_set, ovr_set;
   logic       ferr_d, ovr_d;
   logic       empty;

   // >= keeps ticking sane if BAUDDIV is lowered below the running count.
   assign tick  = EN && (div_q >= BAUDDIV);
   assign div_d = (!EN || tick) ? 8'd0 : div_q + 8'd1;

   always_comb begin
      state_d  = state_q;
      scnt_d   = scnt_q;
      bidx_d   = bidx_q;
      sh_d     = sh_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      if (!EN) begin
         state_d = IDLE;
         scnt_d  = '0;
         bidx_d  = '0;
      end else if (tick) begin
         unique case (state_q)
            IDLE: begin
               if (!rx_s_q) begin
                  state_d = START;
                  scnt_d  = '0;
               end
            end
            START: begin
               if (scnt_q == SMID) begin
                  scnt_d  = '0;
                  bidx_d  = '0;
                  state_d = rx_s_q ? IDLE : DATA;
               end else begin
                  scnt_d = scnt_q + 4'd1;
               end
            end
            DATA: begin
               if (scnt_q == SLAST) begin
                  scnt_d = '0;
                  sh_d   = {rx_s_q, sh_q[7:1]};
                  bidx_d = bidx_q + 3'd1;
                  if (bidx_q == 3'd7) state_d = STOP;
               end else begin
                  scnt_d = scnt_q + 4'd1;
               end
            end
            STOP: begin
               if (scnt_q == SLAST) begin
                  push     = rx_s_q;
                  ferr_set = !rx_s_q;
                  scnt_d   = '0;
                  state_d  = IDLE;
               end else begin
                  scnt_d = scnt_q + 4'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // A same-cycle read makes room, so only an unrelieved full FIFO overruns.
   assign ovr_set = push && RXFULL && !RD;
   assign ferr_d  = ferr_set || (FERR && !CLRERR);
   assign ovr_d   = ovr_set || (OVR && !CLRERR);

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         rx_m_q  <= 1'b1;
         rx_s_q  <= 1'b1;
         div_q   <= '0;
         state_q <= IDLE;
         scnt_q  <= '0;
         bidx_q  <= '0;
         sh_q    <= '0;
         FERR    <= 1'b0;
         OVR     <= 1'b0;
      end else begin
         rx_m_q  <= RX;
         rx_s_q  <= rx_m_q;
         div_q   <= div_d;
         state_q <= state_d;
         scnt_q  <= scnt_d;
         bidx_q  <= bidx_d;
         sh_q    <= sh_d;
         FERR    <= ferr_d;
         OVR     <= ovr_d;
      end
   end

   rx_fifo u_fifo (
      .clk_i   (CLK),
      .rst_ni  (NRST),
      .push_i  (push),
      .wdata_i (sh_q),
      .pop_i   (RD),
      .rdata_o (RDATA),
      .count_o (COUNT),
      .full_o  (RXFULL),
      .empty_o (empty)
   );

   assign RXNE = !empty;

endmodule

// File: tb/tb_uart_receive.sv
// Self-checking bench for uart_receive: frame-level queue model compared
// every idle cycle, plus literal expectations at key points.
module tb_uart_receive;

   logic       CLK = 1'b0;
   logic       NRST, EN, RX, RD, CLRERR;
   logic [7:0] BAUDDIV;
   logic [7:0] RDATA;
   logic       RXNE, RXFULL, FERR, OVR;
   logic [3:0] COUNT;

   int  checks = 0;
   int  failures = 0;
   int  bd = 0;
   bit  chk_en = 1'b0;
   logic [7:0] mq[$];
   bit  mferr = 1'b0;
   bit  movr = 1'b0;

   uart_receive dut (
      .CLK(CLK), .NRST(NRST), .EN(EN), .BAUDDIV(BAUDDIV), .RX(RX),
      .RD(RD), .CLRERR(CLRERR), .RDATA(RDATA), .RXNE(RXNE),
      .RXFULL(RXFULL), .COUNT(COUNT), .FERR(FERR), .OVR(OVR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   // Per-cycle comparison against the frame-level model.
   always @(negedge CLK) begin
      if (chk_en && NRST) begin
         check("m_rdata", RDATA, (mq.size() != 0) ? mq[0] : 8'h00);
         check("m_count", COUNT, mq.size());
         check("m_rxne", RXNE, mq.size() != 0);
         check("m_rxfull", RXFULL, mq.size() == 8);
         check("m_ferr", FERR, mferr);
         check("m_ovr", OVR, movr);
      end
   end

   task automatic send_frame(input logic [7:0] b, input logic stopb);
      int bp;
      bp = 16 * (bd + 1);
      RX = 1'b0;
      repeat (bp) step();
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (bp) step();
      end
      RX = stopb;
      repeat (bp) step();
      RX = 1'b1;
   endtask

   task automatic model_frame(input logic [7:0] b, input logic stopb,
                              input bit rd_same);
      if (!stopb) mferr = 1'b1;
      else if (mq.size() == 8) begin
         if (rd_same) begin
            void'(mq.pop_front());
            mq.push_back(b);
         end else movr = 1'b1;
      end else mq.push_back(b);
   endtask

   task automatic do_frame(input logic [7:0] b, input logic stopb);
      chk_en = 1'b0;
      send_frame(b, stopb);
      model_frame(b, stopb, 1'b0);
      repeat (8) step();
      chk_en = 1'b1;
   endtask

   task automatic do_rd;
      RD = 1'b1;
      step();
      RD = 1'b0;
      if (mq.size() != 0) void'(mq.pop_front());
   endtask

   task automatic do_clr;
      CLRERR = 1'b1;
      step();
      CLRERR = 1'b0;
      mferr = 1'b0;
      movr = 1'b0;
   endtask

   task automatic set_baud(input int v);
      EN = 1'b0;
      BAUDDIV = 8'(v);
      bd = v;
      step();
      EN = 1'b1;
      step();
   endtask

   initial begin
      NRST = 1'b0; EN = 1'b0; RX = 1'b1; RD = 1'b0; CLRERR = 1'b0;
      BAUDDIV = 8'd0;
      repeat (3) step();
      NRST = 1'b1;
      step();
      check("rst_rdata", RDATA, 8'h00);
      check("rst_rxne", RXNE, 1'b0);
      check("rst_rxfull", RXFULL, 1'b0);
      check("rst_count", COUNT, 4'd0);
      check("rst_ferr", FERR, 1'b0);
      check("rst_ovr", OVR, 1'b0);
      EN = 1'b1;
      chk_en = 1'b1;
      repeat (4) step();

      do_frame(8'hA5, 1'b1);
      check("a5_rdata", RDATA, 8'hA5);
      check("a5_rxne", RXNE, 1'b1);
      check("a5_count", COUNT, 4'd1);
      check("a5_ferr", FERR, 1'b0);
      do_rd();
      check("rd_rxne", RXNE, 1'b0);
      check("rd_rdata", RDATA, 8'h00);

      // Start glitch of about 5 ticks is rejected.
      set_baud(3);
      RX = 1'b0;
      repeat (20) step();
      RX = 1'b1;
      repeat (200) step();
      check("glitch_count", COUNT, 4'd0);
      check("glitch_ferr", FERR, 1'b0);
      check("glitch_ovr", OVR, 1'b0);

      set_baud(2);
      do_frame(8'hC3, 1'b1);
      check("bd2_rdata", RDATA, 8'hC3);
      do_rd();
      set_baud(0);

      do_frame(8'h3C, 1'b0);
      check("ferr_set", FERR, 1'b1);
      check("ferr_count", COUNT, 4'd0);
      do_clr();
      check("ferr_clr", FERR, 1'b0);

      // EN dropped mid-frame aborts silently.
      RX = 1'b0;
      repeat (64) step();
      EN = 1'b0;
      RX = 1'b1;
      repeat (20) step();
      EN = 1'b1;
      repeat (200) step();
      check("abort_count", COUNT, 4'd0);
      check("abort_ferr", FERR, 1'b0);
      check("abort_ovr", OVR, 1'b0);

      for (int i = 1; i <= 9; i++) do_frame(8'(i), 1'b1);
      check("ovf_count", COUNT, 4'd8);
      check("ovf_full", RXFULL, 1'b1);
      check("ovf_ovr", OVR, 1'b1);
      check("ovf_rdata", RDATA, 8'h01);
      for (int i = 1; i <= 8; i++) begin
         check("drain_rdata", RDATA, 32'(i));
         do_rd();
      end
      check("drain_rxne", RXNE, 1'b0);
      do_clr();
      check("ovr_clr", OVR, 1'b0);

      for (int i = 0; i < 8; i++) do_frame(8'h11 + 8'(i), 1'b1);
      // RD lands on the push edge, 155 clocks after the start-bit drive.
      chk_en = 1'b0;
      fork
         send_frame(8'h55, 1'b1);
         begin
            repeat (154) step();
            RD = 1'b1;
            step();
            RD = 1'b0;
         end
      join
      model_frame(8'h55, 1'b1, 1'b1);
      repeat (8) step();
      chk_en = 1'b1;
      check("coll_count", COUNT, 4'd8);
      check("coll_ovr", OVR, 1'b0);
      check("coll_full", RXFULL, 1'b1);
      check("coll_head", RDATA, 8'h12);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) check("coll_last", RDATA, 8'h55);
         do_rd();
      end

      do_frame(8'h42, 1'b1);
      do_frame(8'h66, 1'b0);
      chk_en = 1'b0;
      RX = 1'b0;
      repeat (16) step();
      RX = 1'b1;
      repeat (24) step();
      #2 NRST = 1'b0;
      #1;
      check("nrst_rdata", RDATA, 8'h00);
      check("nrst_rxne", RXNE, 1'b0);
      check("nrst_count", COUNT, 4'd0);
      check("nrst_full", RXFULL, 1'b0);
      check("nrst_ferr", FERR, 1'b0);
      check("nrst_ovr", OVR, 1'b0);
      mq.delete();
      mferr = 1'b0;
      movr = 1'b0;
      step();
      step();
      NRST = 1'b1;
      repeat (300) step();
      chk_en = 1'b1;
      do_frame(8'h7E, 1'b1);
      check("post_rdata", RDATA, 8'h7E);
      check("post_count", COUNT, 4'd1);
      check("post_ferr", FERR, 1'b0);

      chk_en = 1'b0;
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_receive.md
# uart_receive

Serial receive path of the UART peripheral, the counterpart of the transmit FIFO. It samples RX with 16x oversampling, paced by the baud-rate divisor register, and deserialises 8N1 frames LSB first. Completed bytes go into an 8-entry receive FIFO that the CPU reads through the data register. It also reports status and error flags to the status register and the interrupt logic.

## Interface
- DEPTH, 8, receive FIFO entries; power of two.
- OVERSAMPLE, 16, sample ticks per bit; fixed, not configurable at run time.
- CLK  in  1  system clock; all state on rising edge.
- NRST  in  1  reset; asynchronous assert, active-low, synchronous release.
- EN  in  1  receiver enable (status bit 0). Low: divider and FSM held in reset, FIFO contents kept.
- BAUDDIV  in  8  divisor; sample tick every BAUDDIV+1 CLK cycles.
- RX  in  1  serial input, asynchronous, idle high.
- RD  in  1  one-cycle pop strobe (CPU read of data register).
- CLRERR  in  1  one-cycle pulse; clears FERR and OVR.
- RDATA  out  8  FIFO head, show-ahead; 8'h00 when empty.
- RXNE  out  1  FIFO not empty.
- RXFULL  out  1  FIFO holds DEPTH bytes.
- COUNT  out  4  bytes held, 0..8.
- FERR  out  1  sticky framing error.
- OVR  out  1  sticky overrun.

## Operation
- Reset values: RDATA=0, RXNE=0, RXFULL=0, COUNT=0, FERR=0, OVR=0, FSM=IDLE, divider=0.
- RX passes through a 2-flop synchroniser (both flops reset to 1). Only the synchronised value rx_s is used.
- Divider: when EN=1, the counter increments each CLK. At BAUDDIV it emits tick for one cycle and wraps to 0. When EN=0, counter=0 and tick=0.
- All FSM actions occur only on tick cycles. The FSM uses a 4-bit sample counter scnt and a 3-bit bit index.
- IDLE: rx_s=0 → START, scnt=0.
- START: scnt counts up. At scnt=7 (mid start bit), rx_s=0 → DATA with scnt=0 and bit index 0. rx_s=1 → IDLE (glitch rejected, nothing recorded).
- DATA: at scnt=15, rx_s is shifted into the MSB of the shift register (right shift, LSB first) and the bit index increments. After the 8th bit → STOP with scnt=0.
- STOP: at scnt=15, rx_s=1 → push the byte. rx_s=0 → discard the byte and set FERR. Either way → IDLE.
- Push to a full FIFO: byte discarded, OVR set, contents unchanged.
- Pop when empty: ignored.
- RD and push in the same cycle:
  - Full FIFO: both performed, COUNT stays 8, no overrun.
  - Empty FIFO: push only, and RD is ignored.
- CLRERR clears both flags. If a set event occurs in the same cycle, the set wins.
- EN falling mid-frame aborts the frame without raising any flag.

## Timing
- Bit period = 16*(BAUDDIV+1) CLK cycles. Start-bit validation happens 8 ticks after the falling edge is seen, so data bits are sampled near their centres.
- Push occurs on the CLK edge ending the stop-sample tick cycle. RXNE, COUNT and RDATA update in that same edge (registered outputs).
- RD at edge n: RDATA shows the next entry and COUNT has decremented after edge n.
- Synchroniser adds 2 CLK of latency on RX.
- Asynchronous NRST at any time, including mid-frame: all outputs go to their reset values immediately and FIFO contents are lost.

## Structure
- The shared package holds a typedef enum logic [1:0] {IDLE, START, DATA, STOP} for the receive state, plus the OVERSAMPLE and DEPTH constants.
- One sub-module, rx_fifo (synchronous show-ahead FIFO with push, pop, count, full and empty). The top contains the synchroniser, divider and FSM.
- Target size: about 200 lines.

## Test plan
- BAUDDIV=0, EN=1; frame 0xA5 at 16 CLK/bit → RDATA=0xA5, RXNE=1, COUNT=1, FERR=0. Then RD pulse → RXNE=0, RDATA=0x00.
- RX low for 5 ticks then high (BAUDDIV=3) → FSM returns to IDLE, COUNT stays 0, no flags.
- Frame 0x3C with stop bit 0 → FERR=1, COUNT unchanged. CLRERR → FERR=0.
- Nine frames 0x01..0x09 with no reads → COUNT=8, RXFULL=1, OVR=1, RDATA=0x01. Eight RD pulses then read back 0x01..0x08.
- FIFO full with RD asserted in the push cycle of byte 0x55 → COUNT=8, OVR=0, 0x55 is last out.
- NRST pulsed during the DATA state of a frame, RX then idles → all outputs 0 and the next clean frame 0x7E is received correctly.
